// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10
    } op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic is_mul(op_t op);
        return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    function automatic logic is_div(op_t op);
        return op inside {DIV, DIVU};
    endfunction

    function automatic logic is_signed(op_t op);
        return op inside {MULT, DIV, MADD, MSUB};
    endfunction

    function automatic logic is_acc(op_t op);
        return op inside {MADD, MADDU, MSUB, MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider on the 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH:0] shl;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shl     = {acc, 1'b0};
        // remainder < divisor keeps a non-negative trial below 2^WIDTH, so bit WIDTH is the sign
        trial   = shl[2*WIDTH:WIDTH] - {1'b0, operand};
        if (div_mode)
            acc_nxt = trial[WIDTH] ? shl[2*WIDTH-1:0] : {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, sign fix-up and write-back in FIX.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  op_t              op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dataRs,
    input  logic [WIDTH-1:0] dataRt,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    op_t                op_q;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   rs_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               neg_res;
    logic               neg_rem;
    logic               div0;

    logic               issue;
    logic               sgn;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_hilo;

    assign busy  = (state != IDLE) | (start & ~cancel & (is_mul(op) | is_div(op)));
    assign issue = (state == IDLE) & start & ~cancel & (is_mul(op) | is_div(op));

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div(op_q)),
        .acc      (acc),
        .operand  (opnd),
        .acc_nxt  (acc_nxt)
    );

    always_comb begin
        sgn    = is_signed(op);
        rs_abs = (sgn && dataRs[WIDTH-1]) ? -dataRs : dataRs;
        rt_abs = (sgn && dataRt[WIDTH-1]) ? -dataRt : dataRt;
    end

    always_comb begin
        prod     = neg_res ? -acc : acc;
        quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hilo = prod;
        // divide by zero reports the raw dividend, bypassing sign correction
        if (is_div(op_q))
            fix_hilo = div0 ? {rs_q, {WIDTH{1'b1}}} : {rem, quo};
        else if (is_acc(op_q) && (op_q inside {MADD, MADDU}))
            fix_hilo = {hi, lo} + prod;
        else if (is_acc(op_q))
            fix_hilo = {hi, lo} - prod;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= NOP;
            opnd    <= '0;
            rs_q    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        op_q    <= op;
                        opnd    <= rt_abs;
                        rs_q    <= dataRs;
                        acc     <= {{WIDTH{1'b0}}, rs_abs};
                        neg_res <= sgn & (dataRs[WIDTH-1] ^ dataRt[WIDTH-1]);
                        neg_rem <= sgn & is_div(op) & dataRs[WIDTH-1];
                        div0    <= (dataRt == '0);
                        cnt     <= CNT_MAX;
                        state   <= CALC;
                    end else if (start && op == MTHI) begin
                        hi <= dataRs;
                    end else if (start && op == MTLO) begin
                        lo <= dataRs;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!cancel) {hi, lo} <= fix_hilo;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench: the driver pushes expected HI/LO and busy length, a monitor checks each busy pulse.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    op_t          op = NOP;
    logic [W-1:0] dataRs = '0;
    logic [W-1:0] dataRt = '0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic         s8_start = 1'b0;
    op_t          s8_op = NOP;
    logic [7:0]   s8_rs = '0;
    logic [7:0]   s8_rt = '0;
    logic         s8_busy;
    logic [7:0]   s8_hi;
    logic [7:0]   s8_lo;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .cancel(cancel),
        .dataRs(dataRs), .dataRt(dataRt), .busy(busy), .hi(hi), .lo(lo)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8_start), .op(s8_op), .cancel(1'b0),
        .dataRs(s8_rs), .dataRt(s8_rt), .busy(s8_busy), .hi(s8_hi), .lo(s8_lo)
    );

    typedef struct {
        logic [63:0] hilo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] m_hilo = '0;
    int          checks = 0;
    int          errors = 0;
    op_t         rops[11] = '{MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, NOP};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero with remainder sign of dividend
    function automatic logic [63:0] ref_res(op_t o, logic [31:0] a, logic [31:0] b, logic [63:0] hilo);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MULT:  return sa * sb;
            MULTU: return ua * ub;
            MADD:  return hilo + sa * sb;
            MADDU: return hilo + ua * ub;
            MSUB:  return hilo - sa * sb;
            MSUBU: return hilo - ua * ub;
            DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return hilo;
        endcase
    endfunction

    initial begin : monitor
        int   bcnt;
        bit   prev;
        exp_t e;
        bcnt = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bcnt++;
                prev = 1;
            end else if (prev) begin
                prev = 0;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy: got pulse of %0d cycles expected none", bcnt);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_hilo"}, {hi, lo}, e.hilo);
                    chk({e.name, "_cycles"}, 64'(bcnt), 64'(e.cycles));
                end
                bcnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: busy got %b expected 0 within 100 cycles", busy);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(op_t o, logic [W-1:0] a, logic [W-1:0] b, int cancel_at = -1, int ign_at = -1);
        bit   multi;
        exp_t e;
        multi = is_mul(o) || is_div(o);
        wait_idle();
        start = 1; op = o; dataRs = a; dataRt = b;
        if (multi) begin
            e.name = o.name();
            if (cancel_at >= 0) begin
                e.hilo = m_hilo;
                e.cycles = cancel_at + 2;
                e.name = {e.name, "_cancel"};
            end else begin
                m_hilo = ref_res(o, a, b, m_hilo);
                e.hilo = m_hilo;
                e.cycles = W + 2;
            end
            sbq.push_back(e);
        end else if (o == MTHI) m_hilo[63:32] = a;
        else if (o == MTLO) m_hilo[31:0] = a;
        @(posedge clk); #1;
        start = 0; op = NOP; dataRs = $urandom; dataRt = $urandom;
        if (multi && (cancel_at >= 0 || ign_at >= 0)) begin
            for (int k = 0; k <= W; k++) begin
                if (k == cancel_at) cancel = 1;
                if (k == ign_at) begin
                    start = 1;
                    op = (k % 2) ? MULT : MTLO;
                    dataRs = 32'hDEAD_BEEF;
                end
                @(posedge clk); #1;
                cancel = 0; start = 0; op = NOP;
                if (k == cancel_at) break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic run8(op_t o, logic [7:0] a, logic [7:0] b, logic [7:0] ehi, logic [7:0] elo, string nm);
        int n = 0;
        @(posedge clk); #1;
        s8_start = 1; s8_op = o; s8_rs = a; s8_rt = b;
        @(negedge clk);
        if (s8_busy) n++;
        @(posedge clk); #1;
        s8_start = 0; s8_op = NOP;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!s8_busy) break;
            n++;
        end
        chk({nm, "_cycles"}, 64'(n), 64'd10);
        chk({nm, "_hi"}, {56'b0, s8_hi}, {56'b0, ehi});
        chk({nm, "_lo"}, {56'b0, s8_lo}, {56'b0, elo});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation got no finish expected one within 50000 cycles");
        $fatal(1);
    end

    initial begin : main
        exp_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_s8", {47'b0, s8_busy, s8_hi, s8_lo}, 64'd0);
        reset_n = 1;

        issue(MULT, 32'hFFFF_FFFE, 32'd3);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MADDU, 32'd2, 32'd3);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        issue(DIVU, 32'd7, 32'd0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd5, 32'd0);
        chk("mtlo_immediate", {hi, lo}, m_hilo);
        issue(MSUB, 32'd2, 32'd3, -1, 5);
        issue(MADD, 32'hFFFF_FFF0, 32'd7, -1, W);
        issue(NOP, 32'd1, 32'd2);
        chk("nop_hilo", {hi, lo}, m_hilo);

        issue(DIV, 32'd100, 32'd7, 9);
        issue(DIV, 32'd100, 32'd7, W);

        issue(MTLO, 32'h55AA_1234, 32'd0);
        wait_idle();
        start = 1; op = MULT; dataRs = $urandom; dataRt = $urandom;
        e.hilo = '0; e.cycles = 6; e.name = "RESET_MID";
        sbq.push_back(e);
        m_hilo = '0;
        @(posedge clk); #1;
        start = 0; op = NOP;
        repeat (5) @(posedge clk);
        #3 reset_n = 0;
        #1;
        chk("async_reset_busy", {63'b0, busy}, 64'd0);
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1;

        for (int i = 0; i < 40; i++)
            issue(rops[$urandom_range(0, 10)], pick(), pick());

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        run8(MULT, 8'hFE, 8'h03, 8'hFF, 8'hFA, "w8_mult");
        run8(DIVU, 8'd200, 8'd7, 8'd4, 8'd28, "w8_divu");
        run8(DIV, 8'h80, 8'hFF, 8'h00, 8'h80, "w8_div_ovf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative, width-parametrised HI/LO multiply/divide unit for the EX stage. It replaces single-cycle `*`, `/` and `%` operators with a one-bit-per-cycle shift-add multiplier and a restoring divider. It supports signed and unsigned MULT/DIV, MADD/MSUB accumulation, MTHI/MTLO writes and a cancel input that flushes in-flight work. While `busy` is high, the pipeline stalls any HI/LO consumer.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Must be at least 4.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: issue strobe for `op`. Sampled on the rising edge.
- `op` input 4: operation code (`muldiv_pkg::op_t`): NOP, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- `cancel` input 1: abort the in-flight operation, e.g. on exception or flush.
- `dataRs` input WIDTH: first operand; also the MTHI/MTLO source.
- `dataRt` input WIDTH: second operand.
- `busy` output 1: unit is occupied or is accepting a multi-cycle op this cycle.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **States.** IDLE, CALC, FIX.
  - Counter `cnt` is `$clog2(WIDTH)` bits.
  - Registers: multiplicand/divisor, a 2·WIDTH partial product or remainder:quotient pair, sign flags, and the op latch.
- **Issue.** Accepted only when in IDLE with `start=1` and `cancel=0`.
  - Signed ops (MULT, DIV, MADD, MSUB) latch the absolute values of the operands plus the result sign flags.
  - Unsigned ops latch the operands unchanged.
  - Go to CALC with `cnt=WIDTH-1`.
- **MTHI/MTLO.** When in IDLE with `start`, write `dataRs` into HI or LO at that edge. Single cycle; `busy` stays low.
- **CALC, multiply.** Each cycle: if the product LSB is 1, add the multiplicand to the upper half; then shift right one bit.
- **CALC, divide.** Each cycle: shift remainder:quotient left by one and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- **Leaving CALC.** When `cnt==0`, go to FIX; otherwise decrement `cnt`.
- **FIX.** Apply sign correction, then write HI/LO and return to IDLE.
  - MULT/MULTU: {HI,LO} = product, negated if the sign flag is set.
  - MADD(U): {HI,LO} = {HI,LO} + product.
  - MSUB(U): {HI,LO} = {HI,LO} − product.
  - All 2·WIDTH arithmetic wraps modulo 2^(2·WIDTH).
  - DIV(U): LO = quotient, HI = remainder. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
- **Divide by zero.** The operation still takes full latency. LO = all ones, HI = `dataRs` as latched, with no sign correction.
- **Signed overflow.** MIN / −1 gives LO = MIN and HI = 0.
- **Cancel.** `cancel=1` in CALC or FIX returns the FSM to IDLE at the next edge with HI/LO unchanged. Cancel has priority over a FIX write-back.
- **Ignored starts.** `start` while not in IDLE is ignored, including MTHI/MTLO. The pipeline must hold the instruction until `busy` is low.
- **NOP.** `start` with NOP does nothing.

## Timing
- **Reset.** `reset_n` low asynchronously forces IDLE, `cnt=0`, HI=0, LO=0, `busy=0`. Reset mid-operation discards the operation.
- **busy definition.** `busy = (state!=IDLE) | (start & ~cancel & op∈{MULT..MSUBU})`. The combinational term lets the issuing instruction stall a following MFHI/MFLO in the same cycle.
- **Latency.** For an op accepted at edge E0, `busy` is high in the E0 cycle plus WIDTH CALC cycles plus one FIX cycle, i.e. WIDTH+2 cycles. New HI/LO are visible after edge E0+WIDTH+1, and IDLE is reached at that same edge.
- **Back-to-back.** A new op can be accepted at edge E0+WIDTH+2 at the earliest. A start presented in the first IDLE cycle is accepted at that edge, so there are no bubbles.
- **MTHI/MTLO.** HI/LO are updated at the accepting edge, with zero added latency.
- **Outputs.** `hi` and `lo` are pure register outputs; no MFHI/MFLO mux lives here.

## Structure
- **Package `muldiv_pkg`:** `op_t` enum, `state_t` enum {IDLE, CALC, FIX}, helper functions `is_mul(op)`, `is_div(op)`, `is_signed(op)`, `is_acc(op)`.
- **Sub-module `muldiv_step`:** purely combinational, parametrised by `WIDTH`. It computes one multiply or divide iteration from (mode, acc, operand) to next acc. This keeps the FSM file free of datapath logic.
- **Top.** The FSM, counter, operand/sign latches and FIX correction live in `muldiv_iter`.

## Test plan
- **Signed multiply.** WIDTH=32; MULT with `dataRs`=0xFFFFFFFE (−2) and `dataRt`=3. Expect HI=0xFFFFFFFF and LO=0xFFFFFFFA at E0+33; `busy` high for exactly 34 cycles.
- **Unsigned multiply.** MULTU with 0xFFFFFFFF × 0xFFFFFFFF. Expect HI=0xFFFFFFFE and LO=0x00000001. Follow with MADDU 2×3, giving LO=0x00000007 and HI unchanged.
- **Signed divide.** DIV −7 / 2 gives LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU 7/0 gives LO=0xFFFFFFFF and HI=7. DIV 0x80000000 / −1 gives LO=0x80000000 and HI=0.
- **MSUB and register writes.** MTHI 0, MTLO 5, then MSUB 2×3. Expect {HI,LO}=0xFFFFFFFF_FFFFFFFF. A start issued while busy is ignored; check HI/LO and the cycle count.
- **Cancel.** Assert `cancel` at cycle 10 of a DIV. Expect IDLE next cycle, `busy`=0 and HI/LO equal to their pre-issue values. Repeat with `cancel` in the FIX cycle; expect no write-back.
- **Reset.** Drop `reset_n` asynchronously mid-CALC. Expect `busy`, HI and LO to go to 0 before the next edge. Rerun the first scenario at WIDTH=8: 0xFE×0x03 gives HI=0xFF and LO=0xFA, with `busy` high for 10 cycles.
